leaf_out_arbiter: RTL
=====================

// Module: leaf_out_arbiter
// PURPOSE
//  Round-robin arbiter that shares one leaf_interface user output port between NUM_REQ operator output streams.
//  Sits between the user operators' Output_*_V_V ap_vld/ap_ack ports and the interface's
//  din_leaf_user2interface/vld_user2interface/ack_interface2user port, all in the clk_user domain.
//  Registered single-entry output stage; sustains one word per cycle; emits the source index alongside the data.
// PARAMETERS
//  NUM_REQ       4   number of requesting operator output streams (2..16)
//  PAYLOAD_BITS  32  word width, equals the interface PAYLOAD_BITS
//  BURST_LEN     1   max consecutive grants to one requester while any other requester is valid (1..255)
// PORTS
//  clk_user   in   1                    single clock; all logic is clocked on its rising edge
//  reset      in   1                    synchronous, active-high
//  din_req    in   NUM_REQ*PAYLOAD_BITS requester words, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//  vld_req    in   NUM_REQ              requester ap_vld
//  ack_req    out  NUM_REQ              requester ap_ack, one-hot or zero, combinational
//  dout       out  PAYLOAD_BITS         word to the interface
//  vld_out    out  1                    output word valid, registered
//  ack_out    in   1                    interface accepts dout this cycle
//  src_id     out  $clog2(NUM_REQ)      index of the requester that produced dout
//  busy       out  1                    vld_out | (|vld_req)
// BEHAVIOUR
//  - Transfer rule on both sides: a word moves in a cycle where vld && ack are both high. ack never waits on a later cycle.
//  - Reset values: vld_out=0, dout=0, src_id=0, ack_req=0, rr_ptr=0, burst_cnt=0, state=EMPTY. Any word held at reset is dropped.
//  - FSM, 2 states:
//    - EMPTY: the output register is free. accept = |vld_req.
//    - FULL: the output register holds a word. accept = ack_out && |vld_req.
//    - Transitions: EMPTY->FULL on accept; FULL->EMPTY on ack_out && !accept; FULL->FULL on accept (back-to-back).
//  - Grant selection (combinational, only when accept is high):
//    - Normal case: g = first i with vld_req[i], searching from rr_ptr upward and wrapping past NUM_REQ-1 to 0.
//    - Exception: if the last granted index L has vld_req[L]=1 and burst_cnt < BURST_LEN, keep g = L.
//    - ack_req = onehot(g) when accept, else 0.
//  - On accept at the clock edge:
//    - dout <= din_req[g]; src_id <= g; vld_out <= 1.
//    - Same requester as the last grant: burst_cnt <= burst_cnt+1. Different requester: burst_cnt <= 1.
//    - rr_ptr <= g+1 mod NUM_REQ when the grant will rotate next (burst_cnt+1 == BURST_LEN, or no other requester valid); else rr_ptr holds.
//    - A single active requester is never starved and is never limited by BURST_LEN: the burst limit only applies while others are valid.
//  - Latency: requester handshake at cycle t gives vld_out=1 at cycle t+1.
//  - Throughput: 1 word/cycle while ack_out=1.
//  - Back-pressure: while FULL && !ack_out, ack_req=0 and dout/src_id/vld_out hold stable.
//  - Fairness: with all NUM_REQ valid and BURST_LEN=1, grants are strictly cyclic. No requester waits more than (NUM_REQ-1)*BURST_LEN accepts.
//  - Simultaneous ack_out and new accept: the old word leaves and the new word loads in the same edge, with no bubble.
//  - Width rules: burst_cnt is 8 bits and saturates at 255. rr_ptr wrap uses an explicit compare, not power-of-two truncation.
// CONFIGURATION
//  LEAF_ARB_STATS_EN defined:
//    - Adds ports stat_sel (in, $clog2(NUM_REQ)) and stat_cnt (out, 16).
//    - One 16-bit saturating grant counter per requester, incremented on each accept for that requester.
//    - Counters clear on reset.
//    - stat_cnt is the registered value of counter[stat_sel], one-cycle latency.
//  Undefined: the counters and both ports are absent, and the arbitration behaviour is unchanged.
// STRUCTURE
//  Package leaf_arb_pkg:
//    - typedef enum {EMPTY, FULL} arb_state_t
//    - localparam BURST_CNT_BITS = 8
//    - localparam STAT_BITS = 16
//    - function clog2_min1(n): returns max(1, $clog2(n))
//  Sub-module rr_pick: purely combinational; inputs req[NUM_REQ] and ptr; outputs found and idx.
//    Instantiated once for the rotating search. The burst-hold override stays in the top module.
// TESTING
//  1. Reset, vld_req=0 -> vld_out=0, ack_req=0, busy=0, src_id=0.
//  2. Only req1 valid with 0xA5, ack_out=1 -> ack_req=4'b0010 at t; vld_out=1, dout=0x000000A5, src_id=1 at t+1.
//  3. All 4 valid, ack_out=1, BURST_LEN=1 -> src_id sequence 0,1,2,3,0 over 5 cycles, no idle cycle.
//  4. All valid, ack_out=0 for 3 cycles after the first word -> ack_req=0, dout/src_id stable.
//     After ack_out rises, the next word follows on the very next cycle.
//  5. BURST_LEN=3, req0 and req2 valid -> src_id 0,0,0,2,2,2,0. With only req0 valid, 0 repeats indefinitely.
//  6. Reset asserted while FULL with ack_out=0 -> next cycle vld_out=0; first grant after release searches from index 0.
//     With LEAF_ARB_STATS_EN, stat_cnt reads 0 for all stat_sel.

Source files
------------

// File: rtl/leaf_arb_pkg.sv
// ---------------------------------------------------------------------------
// leaf_arb_pkg : shared types and constants for the leaf output arbiter.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package leaf_arb_pkg;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   localparam int BURST_CNT_BITS = 8;
   localparam int STAT_BITS      = 16;

   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/leaf_out_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational rotating search, first set bit at or above ptr.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import leaf_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PTR_BITS = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [PTR_BITS-1:0] ptr,
   output logic                found,
   output logic [PTR_BITS-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         int                  c;
         logic [PTR_BITS-1:0] ci;
         c = int'(ptr) + j;
         if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
         end
         ci = PTR_BITS'(c);
         if (req[ci]) begin
            found = 1'b1;
            idx   = ci;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter : round-robin, burst-limited arbiter with a registered
//                    single-entry output stage. Optional grant statistics
//                    are built when LEAF_ARB_STATS_EN is defined.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module leaf_out_arbiter
   import leaf_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int PAYLOAD_BITS = 32,
   parameter int BURST_LEN    = 1
) (
   input  logic                            clk_user,
   input  logic                            reset,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
   input  logic [NUM_REQ-1:0]              vld_req,
   output logic [NUM_REQ-1:0]              ack_req,
   output logic [PAYLOAD_BITS-1:0]         dout,
   output logic                            vld_out,
   input  logic                            ack_out,
   output logic [$clog2(NUM_REQ)-1:0]      src_id,
   output logic                            busy
`ifdef LEAF_ARB_STATS_EN
   ,
   input  logic [$clog2(NUM_REQ)-1:0]      stat_sel,
   output logic [STAT_BITS-1:0]            stat_cnt
`endif
);

   localparam int                          IDX_BITS  = clog2_min1(NUM_REQ);
   localparam logic [BURST_CNT_BITS-1:0]   BURST_MAX = BURST_CNT_BITS'(BURST_LEN);
   localparam logic [IDX_BITS-1:0]         LAST_IDX  = IDX_BITS'(NUM_REQ - 1);

   arb_state_t                  state_q, state_d;
   logic [IDX_BITS-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDX_BITS-1:0]         src_id_q, src_id_d;
   logic [BURST_CNT_BITS-1:0]   burst_cnt_q, burst_cnt_d;
   logic [PAYLOAD_BITS-1:0]     dout_q, dout_d;

   logic                        pick_found;
   logic [IDX_BITS-1:0]         pick_idx;
   logic                        accept;
   logic                        hold_last;
   logic                        others_valid;
   logic [IDX_BITS-1:0]         grant;
   logic [NUM_REQ-1:0]          grant_oh;
   logic [BURST_CNT_BITS-1:0]   cnt_next;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .PTR_BITS (IDX_BITS)
   ) u_pick (
      .req   (vld_req),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      src_id_d    = src_id_q;
      burst_cnt_d = burst_cnt_q;
      dout_d      = dout_q;
      ack_req     = '0;
      grant_oh    = '0;

      unique case (state_q)
         EMPTY:   accept = pick_found;
         FULL:    accept = ack_out && pick_found;
         default: accept = 1'b0;
      endcase

      // The last winner keeps the port while its burst allowance lasts.
      hold_last = vld_req[src_id_q] && (burst_cnt_q < BURST_MAX);
      grant     = hold_last ? src_id_q : pick_idx;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == IDX_BITS'(i)) begin
            grant_oh[i] = 1'b1;
         end
      end
      others_valid = |(vld_req & ~grant_oh);

      if (grant == src_id_q) begin
         cnt_next = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + BURST_CNT_BITS'(1);
      end else begin
         cnt_next = BURST_CNT_BITS'(1);
      end

      if (accept) begin
         ack_req     = grant_oh;
         state_d     = FULL;
         src_id_d    = grant;
         burst_cnt_d = cnt_next;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
               dout_d = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
         end
         if ((cnt_next == BURST_MAX) || !others_valid) begin
            rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + IDX_BITS'(1);
         end
      end else if ((state_q == FULL) && ack_out) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk_user) begin
      if (reset) begin
         state_q     <= EMPTY;
         rr_ptr_q    <= '0;
         src_id_q    <= '0;
         burst_cnt_q <= '0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         src_id_q    <= src_id_d;
         burst_cnt_q <= burst_cnt_d;
         dout_q      <= dout_d;
      end
   end

   assign vld_out = (state_q == FULL);
   assign dout    = dout_q;
   assign src_id  = src_id_q;
   assign busy    = vld_out | (|vld_req);

`ifdef LEAF_ARB_STATS_EN
   logic [NUM_REQ*STAT_BITS-1:0] stat_flat;
   logic [STAT_BITS-1:0]         stat_rd;
   logic [STAT_BITS-1:0]         stat_cnt_q;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [STAT_BITS-1:0] cnt_q;

      always_ff @(posedge clk_user) begin
         if (reset) begin
            cnt_q <= '0;
         end else if (accept && grant_oh[gi] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STAT_BITS'(1);
         end
      end

      assign stat_flat[gi*STAT_BITS +: STAT_BITS] = cnt_q;
   end

   always_comb begin
      stat_rd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel == IDX_BITS'(i)) begin
            stat_rd = stat_flat[i*STAT_BITS +: STAT_BITS];
         end
      end
   end

   always_ff @(posedge clk_user) begin
      if (reset) begin
         stat_cnt_q <= '0;
      end else begin
         stat_cnt_q <= stat_rd;
      end
   end

   assign stat_cnt = stat_cnt_q;
`endif

endmodule

`default_nettype wire
